id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline.
- Captures decoded control, operands and register specifiers from ID, and presents them to EX.
- Drives EX_rt and EX_MemRead back to the load-use hazard detector.
- Consumes that detector's nop_mux request by inserting a bubble. Also handles branch flush and downstream hold.

Parameters:
- DATA_W, 32, width of PC+4, operand and immediate fields
- REG_AW, 5, register specifier width

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-low reset
- nop_mux  input  1  bubble request from hazard detector (load-use stall)
- flush  input  1  branch-taken squash of the ID-stage instruction
- EX_Hold  input  1  downstream hold; freeze register contents
- ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch, ID_ALUSrc, ID_RegDst  input  1 each  decoded control
- ID_ALUOp  input  2  ALU op class
- ID_PC4, ID_ReadData1, ID_ReadData2, ID_SignExt  input  DATA_W each  ID datapath values
- ID_rs, ID_rt, ID_rd  input  REG_AW each  register specifiers
- EX_*  output  same widths  registered copies of every ID_* input above (EX_RegWrite ... EX_rd)
- EX_Valid  output  1  1 = EX holds a real instruction, 0 = bubble

Behaviour:
- Clock and reset: single clock; all state updates on the rising edge of clk. reset is synchronous and active-low.
- Reset: while reset=0 at a clock edge, all EX_* outputs and EX_Valid are cleared to 0. This clears EX_MemRead, so no false stall follows reset.
- Per-edge priority (first match wins):
  1. reset=0: clear everything.
  2. EX_Hold=1: all registers keep their value. Hold also beats flush and nop_mux; the hazard unit/PC logic keep their requests asserted while held.
  3. flush=1 or nop_mux=1: insert a bubble. Every EX_* field and EX_Valid load 0, data fields included, for deterministic waveforms.
  4. Otherwise: load all ID_* fields and set EX_Valid=1.
- Latency: exactly 1 cycle from ID_* to EX_*.
- Combinational paths: none from inputs to outputs.
- Hazard loop timing:
  - A load in EX with EX_rt matching the ID rs/rt causes nop_mux=1.
  - The next edge writes a bubble, so EX_MemRead=0 in the following cycle.
  - The hazard request therefore deasserts, and the stalled instruction (held in IF/ID) loads on the subsequent edge.
  - Net stall per load-use hazard: 1 bubble.
- Back-to-back nop_mux for 2+ cycles: each cycle inserts a bubble; no counting or saturation.
- flush together with nop_mux: single bubble; no difference from either alone.
- Reset asserted mid-hold or mid-stall: reset wins. After reset release, the first normal edge loads ID.
- No X-propagation: every register has a reset value.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - Adds output bubble_count (32 bits) and output load_use_count (32 bits).
  - bubble_count increments on every non-held, non-reset edge where flush|nop_mux=1.
  - load_use_count increments only when nop_mux=1 and flush=0.
  - Both clear on reset, wrap modulo 2^32, and freeze under EX_Hold.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - constants DATA_W=32, REG_AW=5, ALUOP_W=2;
  - localparam ALUOP_RTYPE=2'b10, ALUOP_ADD=2'b00, ALUOP_SUB=2'b01;
  - a packed control-bundle typedef ctrl_t with fields RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, ALUOp.
- One natural sub-module: pipe_field_reg, a width-parameterised register with sync active-low clear, hold and bubble-zero inputs. It is instantiated per field group (control, data, specifiers).
- Counters live in the top module under the macro.

Test Plan:
- Reset: drive reset=0 for 2 edges with ID_* all-ones -> all EX_* = 0, EX_Valid=0, EX_MemRead=0.
- Normal load: ID_RegWrite=1, ID_rt=5'd9, ID_ReadData1=32'h0000_00AA, reset=1 -> next cycle EX_rt=9, EX_ReadData1=32'hAA, EX_Valid=1.
- Load-use loop:
  - Stimulus: lw with ID_MemRead=1, ID_rt=8 loaded, then the hazard model drives nop_mux=1 for one cycle.
  - Bubble cycle: all EX_* = 0 and EX_Valid=0.
  - Following edge: the dependent add with rs=8 appears in EX.
  - Counters: with ID_EX_BUBBLE_CNT_EN, bubble_count=1 and load_use_count=1.
- Hold priority: EX_Hold=1 with nop_mux=1 and flush=1 for 3 cycles -> EX_* unchanged from the prior value; counters unchanged.
- Flush + nop_mux together: one bubble; bubble_count +1 and load_use_count +0.
- Reset mid-stall: nop_mux=1, EX_Hold=1, reset=0 on one edge -> all cleared. Next edge with reset=1 and no requests loads ID values with EX_Valid=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline registers: datapath widths,
// ALUOp encodings and the packed control bundle carried from ID to EX.
package pipe_pkg;

   localparam int DATA_W  = 32;
   localparam int REG_AW  = 5;
   localparam int ALUOP_W = 2;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

   typedef struct packed {
      logic               RegWrite;
      logic               MemtoReg;
      logic               MemRead;
      logic               MemWrite;
      logic               Branch;
      logic               ALUSrc;
      logic               RegDst;
      logic [ALUOP_W-1:0] ALUOp;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipe_field_reg.sv
// Width-parameterised pipeline field register. Priority on each rising edge:
// synchronous active-low clear, then hold, then bubble (load zero), else load.
module pipe_field_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_hold,
   input  logic         i_bubble,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Field storage: clear, freeze, squash to zero, or capture the new value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q <= '0;
      end else if (i_hold) begin
         r_q <= r_q;
      end else if (i_bubble) begin
         r_q <= '0;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. Captures decoded control, operands and register
// specifiers from ID for use in EX one cycle later. A bubble (all fields and
// EX_Valid zero) is inserted on flush or a load-use nop_mux request, and
// EX_Hold freezes everything. Defining ID_EX_BUBBLE_CNT_EN adds the
// bubble_count and load_use_count statistic outputs.
module id_ex_stage_reg #(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int REG_AW = pipe_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              nop_mux,
   input  logic              flush,
   input  logic              EX_Hold,
   input  logic              ID_RegWrite,
   input  logic              ID_MemtoReg,
   input  logic              ID_MemRead,
   input  logic              ID_MemWrite,
   input  logic              ID_Branch,
   input  logic              ID_ALUSrc,
   input  logic              ID_RegDst,
   input  logic [1:0]        ID_ALUOp,
   input  logic [DATA_W-1:0] ID_PC4,
   input  logic [DATA_W-1:0] ID_ReadData1,
   input  logic [DATA_W-1:0] ID_ReadData2,
   input  logic [DATA_W-1:0] ID_SignExt,
   input  logic [REG_AW-1:0] ID_rs,
   input  logic [REG_AW-1:0] ID_rt,
   input  logic [REG_AW-1:0] ID_rd,
   output logic              EX_RegWrite,
   output logic              EX_MemtoReg,
   output logic              EX_MemRead,
   output logic              EX_MemWrite,
   output logic              EX_Branch,
   output logic              EX_ALUSrc,
   output logic              EX_RegDst,
   output logic [1:0]        EX_ALUOp,
   output logic [DATA_W-1:0] EX_PC4,
   output logic [DATA_W-1:0] EX_ReadData1,
   output logic [DATA_W-1:0] EX_ReadData2,
   output logic [DATA_W-1:0] EX_SignExt,
   output logic [REG_AW-1:0] EX_rs,
   output logic [REG_AW-1:0] EX_rt,
   output logic [REG_AW-1:0] EX_rd,
   output logic              EX_Valid
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [31:0]       bubble_count,
   output logic [31:0]       load_use_count
`endif
);

   import pipe_pkg::*;

   localparam int DATA_GRP_W = 4 * DATA_W;
   localparam int SPEC_GRP_W = 3 * REG_AW;

   logic                  w_bubble;
   ctrl_t                 w_idCtrl;
   ctrl_t                 w_exCtrl;
   logic [DATA_GRP_W-1:0] w_idData;
   logic [DATA_GRP_W-1:0] w_exData;
   logic [SPEC_GRP_W-1:0] w_idSpec;
   logic [SPEC_GRP_W-1:0] w_exSpec;

   // Flush and load-use stall both squash the incoming instruction identically.
   assign w_bubble = flush | nop_mux;

   assign w_idCtrl.RegWrite = ID_RegWrite;
   assign w_idCtrl.MemtoReg = ID_MemtoReg;
   assign w_idCtrl.MemRead  = ID_MemRead;
   assign w_idCtrl.MemWrite = ID_MemWrite;
   assign w_idCtrl.Branch   = ID_Branch;
   assign w_idCtrl.ALUSrc   = ID_ALUSrc;
   assign w_idCtrl.RegDst   = ID_RegDst;
   assign w_idCtrl.ALUOp    = ID_ALUOp;

   assign w_idData = {ID_PC4, ID_ReadData1, ID_ReadData2, ID_SignExt};
   assign w_idSpec = {ID_rs, ID_rt, ID_rd};

   pipe_field_reg #(.W(CTRL_W)) u_ctrlReg (
      .clk      (clk),
      .reset    (reset),
      .i_hold   (EX_Hold),
      .i_bubble (w_bubble),
      .i_d      (w_idCtrl),
      .o_q      (w_exCtrl)
   );

   pipe_field_reg #(.W(DATA_GRP_W)) u_dataReg (
      .clk      (clk),
      .reset    (reset),
      .i_hold   (EX_Hold),
      .i_bubble (w_bubble),
      .i_d      (w_idData),
      .o_q      (w_exData)
   );

   pipe_field_reg #(.W(SPEC_GRP_W)) u_specReg (
      .clk      (clk),
      .reset    (reset),
      .i_hold   (EX_Hold),
      .i_bubble (w_bubble),
      .i_d      (w_idSpec),
      .o_q      (w_exSpec)
   );

   // The valid flag loads a constant 1, so a bubble or reset is what marks EX empty.
   pipe_field_reg #(.W(1)) u_validReg (
      .clk      (clk),
      .reset    (reset),
      .i_hold   (EX_Hold),
      .i_bubble (w_bubble),
      .i_d      (1'b1),
      .o_q      (EX_Valid)
   );

   assign EX_RegWrite = w_exCtrl.RegWrite;
   assign EX_MemtoReg = w_exCtrl.MemtoReg;
   assign EX_MemRead  = w_exCtrl.MemRead;
   assign EX_MemWrite = w_exCtrl.MemWrite;
   assign EX_Branch   = w_exCtrl.Branch;
   assign EX_ALUSrc   = w_exCtrl.ALUSrc;
   assign EX_RegDst   = w_exCtrl.RegDst;
   assign EX_ALUOp    = w_exCtrl.ALUOp;

   assign {EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignExt} = w_exData;
   assign {EX_rs, EX_rt, EX_rd} = w_exSpec;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] r_bubbleCount;
   logic [31:0] r_loadUseCount;

   // Statistics: every inserted bubble, and separately those caused purely by load-use.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bubbleCount  <= '0;
         r_loadUseCount <= '0;
      end else if (!EX_Hold) begin
         if (w_bubble) begin
            r_bubbleCount <= r_bubbleCount + 32'd1;
         end
         if (nop_mux && !flush) begin
            r_loadUseCount <= r_loadUseCount + 32'd1;
         end
      end
   end

   assign bubble_count   = r_bubbleCount;
   assign load_use_count = r_loadUseCount;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: a table of directed vectors with
// hand-computed expected EX contents, followed by a load-use hazard loop
// driven by a small hazard-detector model. Counter checks are compiled in
// when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage_reg;

   import pipe_pkg::*;

   typedef struct packed {
      logic        valid;
      ctrl_t       ctrl;
      logic [31:0] pc4;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] se;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } bundle_t;

   typedef struct {
      logic        rstN;
      logic        nop;
      logic        flsh;
      logic        hold;
      bundle_t     in;
      bundle_t     exp;
      logic [31:0] expBub;
      logic [31:0] expLu;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        nop_mux;
   logic        flush;
   logic        EX_Hold;
   bundle_t     inBus;
   bundle_t     actBus;
   logic        EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite;
   logic        EX_Branch, EX_ALUSrc, EX_RegDst;
   logic [1:0]  EX_ALUOp;
   logic [31:0] EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignExt;
   logic [4:0]  EX_rs, EX_rt, EX_rd;
   logic        EX_Valid;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_count;
   logic [31:0] load_use_count;
`endif

   int checks   = 0;
   int failures = 0;

   id_ex_stage_reg dut (
      .clk          (clk),
      .reset        (reset),
      .nop_mux      (nop_mux),
      .flush        (flush),
      .EX_Hold      (EX_Hold),
      .ID_RegWrite  (inBus.ctrl.RegWrite),
      .ID_MemtoReg  (inBus.ctrl.MemtoReg),
      .ID_MemRead   (inBus.ctrl.MemRead),
      .ID_MemWrite  (inBus.ctrl.MemWrite),
      .ID_Branch    (inBus.ctrl.Branch),
      .ID_ALUSrc    (inBus.ctrl.ALUSrc),
      .ID_RegDst    (inBus.ctrl.RegDst),
      .ID_ALUOp     (inBus.ctrl.ALUOp),
      .ID_PC4       (inBus.pc4),
      .ID_ReadData1 (inBus.rd1),
      .ID_ReadData2 (inBus.rd2),
      .ID_SignExt   (inBus.se),
      .ID_rs        (inBus.rs),
      .ID_rt        (inBus.rt),
      .ID_rd        (inBus.rd),
      .EX_RegWrite  (EX_RegWrite),
      .EX_MemtoReg  (EX_MemtoReg),
      .EX_MemRead   (EX_MemRead),
      .EX_MemWrite  (EX_MemWrite),
      .EX_Branch    (EX_Branch),
      .EX_ALUSrc    (EX_ALUSrc),
      .EX_RegDst    (EX_RegDst),
      .EX_ALUOp     (EX_ALUOp),
      .EX_PC4       (EX_PC4),
      .EX_ReadData1 (EX_ReadData1),
      .EX_ReadData2 (EX_ReadData2),
      .EX_SignExt   (EX_SignExt),
      .EX_rs        (EX_rs),
      .EX_rt        (EX_rt),
      .EX_rd        (EX_rd),
      .EX_Valid     (EX_Valid)
`ifdef ID_EX_BUBBLE_CNT_EN
      ,
      .bubble_count   (bubble_count),
      .load_use_count (load_use_count)
`endif
   );

   // Gather the DUT outputs into one bundle so a whole EX snapshot compares at once.
   always_comb begin
      actBus               = '0;
      actBus.valid         = EX_Valid;
      actBus.ctrl.RegWrite = EX_RegWrite;
      actBus.ctrl.MemtoReg = EX_MemtoReg;
      actBus.ctrl.MemRead  = EX_MemRead;
      actBus.ctrl.MemWrite = EX_MemWrite;
      actBus.ctrl.Branch   = EX_Branch;
      actBus.ctrl.ALUSrc   = EX_ALUSrc;
      actBus.ctrl.RegDst   = EX_RegDst;
      actBus.ctrl.ALUOp    = EX_ALUOp;
      actBus.pc4           = EX_PC4;
      actBus.rd1           = EX_ReadData1;
      actBus.rd2           = EX_ReadData2;
      actBus.se            = EX_SignExt;
      actBus.rs            = EX_rs;
      actBus.rt            = EX_rt;
      actBus.rd            = EX_rd;
   end

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input bundle_t act, input bundle_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      reset   = v.rstN;
      nop_mux = v.nop;
      flush   = v.flsh;
      EX_Hold = v.hold;
      inBus   = v.in;
      @(posedge clk);
      #1;
   endtask

   function automatic bundle_t withValid(input bundle_t b, input logic v);
      bundle_t r;
      r       = b;
      r.valid = v;
      return r;
   endfunction

   function automatic vec_t mkVec(input logic rstN, input logic nop, input logic flsh,
                                  input logic hold, input bundle_t in, input bundle_t exp,
                                  input logic [31:0] expBub, input logic [31:0] expLu);
      vec_t v;
      v.rstN   = rstN;
      v.nop    = nop;
      v.flsh   = flsh;
      v.hold   = hold;
      v.in     = in;
      v.exp    = exp;
      v.expBub = expBub;
      v.expLu  = expLu;
      return v;
   endfunction

   bundle_t zeroB, onesB, normB, lwB, addB;
   vec_t    vecs[$];

   initial begin
      int  stalls;
      bit  done;
      bit  nopReq;

      reset   = 1'b0;
      nop_mux = 1'b0;
      flush   = 1'b0;
      EX_Hold = 1'b0;

      zeroB = '0;
      onesB = '1;

      normB               = '0;
      normB.ctrl.RegWrite = 1'b1;
      normB.rt            = 5'd9;
      normB.rd1           = 32'h0000_00AA;

      lwB               = '0;
      lwB.ctrl.RegWrite = 1'b1;
      lwB.ctrl.MemtoReg = 1'b1;
      lwB.ctrl.MemRead  = 1'b1;
      lwB.ctrl.ALUSrc   = 1'b1;
      lwB.ctrl.ALUOp    = ALUOP_ADD;
      lwB.pc4           = 32'h0000_0104;
      lwB.rd1           = 32'h0000_1000;
      lwB.rd2           = 32'h1234_5678;
      lwB.se            = 32'h0000_0004;
      lwB.rs            = 5'd29;
      lwB.rt            = 5'd8;

      addB               = '0;
      addB.ctrl.RegWrite = 1'b1;
      addB.ctrl.RegDst   = 1'b1;
      addB.ctrl.ALUOp    = ALUOP_RTYPE;
      addB.pc4           = 32'h0000_0108;
      addB.rd1           = 32'h0000_0055;
      addB.rd2           = 32'h0000_0066;
      addB.se            = 32'h0000_5820;
      addB.rs            = 5'd8;
      addB.rt            = 5'd10;
      addB.rd            = 5'd11;

      //                 rstN  nop   flsh  hold  in     expected EX                bub lu
      vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b0, onesB, zeroB,                    0, 0));
      vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b0, onesB, zeroB,                    0, 0));
      vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, normB, withValid(normB, 1'b1),   0, 0));
      vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, lwB,   withValid(lwB, 1'b1),     0, 0));
      vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 1'b0, addB,  zeroB,                    1, 1));
      vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, addB,  withValid(addB, 1'b1),    1, 1));
      vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 1'b1, lwB,   withValid(addB, 1'b1),    1, 1));
      vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 1'b1, lwB,   withValid(addB, 1'b1),    1, 1));
      vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 1'b1, lwB,   withValid(addB, 1'b1),    1, 1));
      vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 1'b0, lwB,   zeroB,                    2, 1));
      vecs.push_back(mkVec(1'b1, 1'b0, 1'b1, 1'b0, addB,  zeroB,                    3, 1));
      vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, lwB,   withValid(lwB, 1'b1),     3, 1));
      vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 1'b0, addB,  zeroB,                    4, 2));
      vecs.push_back(mkVec(1'b1, 1'b1, 1'b0, 1'b0, addB,  zeroB,                    5, 3));
      vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, addB,  withValid(addB, 1'b1),    5, 3));
      vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b1, lwB,   zeroB,                    0, 0));
      vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, lwB,   withValid(lwB, 1'b1),     0, 0));
      vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b1, addB,  withValid(lwB, 1'b1),     0, 0));
      vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, onesB, withValid(onesB, 1'b1),   0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), actBus, vecs[i].exp);
`ifdef ID_EX_BUBBLE_CNT_EN
         checkWord($sformatf("vec%0d_bubble_count", i), bubble_count, vecs[i].expBub);
         checkWord($sformatf("vec%0d_load_use_count", i), load_use_count, vecs[i].expLu);
`endif
      end

      // Load-use loop: lw writing $8 enters EX, then the dependent add waits in ID.
      applyStimulus(mkVec(1'b1, 1'b0, 1'b0, 1'b0, lwB, withValid(lwB, 1'b1), 0, 0));
      checkOutput("lw_in_ex", actBus, withValid(lwB, 1'b1));

      stalls = 0;
      done   = 1'b0;
      for (int c = 0; c < 5 && !done; c++) begin
         @(negedge clk);
         inBus   = addB;
         nopReq  = EX_MemRead && ((EX_rt == addB.rs) || (EX_rt == addB.rt));
         nop_mux = nopReq;
         if (nopReq) begin
            stalls++;
         end else begin
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         if (nopReq) begin
            checkOutput($sformatf("load_use_bubble%0d", stalls), actBus, zeroB);
         end
      end
      if (!done) begin
         failures++;
         $display("[TB] FAIL load_use_timeout: got %0d stall cycles expected 1", stalls);
      end
      checkWord("load_use_stalls", stalls, 1);
      checkOutput("dependent_add_in_ex", actBus, withValid(addB, 1'b1));
`ifdef ID_EX_BUBBLE_CNT_EN
      checkWord("load_use_bubble_count", bubble_count, 32'd1);
      checkWord("load_use_load_use_count", load_use_count, 32'd1);
`endif

      nop_mux = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
